multicycle_adder_ctrl: RTL and testbench
========================================

// Module: multicycle_adder_ctrl
// PURPOSE
//   Sequencer that time-shares one full_adder_4bit slice to add or subtract WIDTH-bit operands,
//   one nibble per clock, LSB nibble first, with the carry held in a register between nibbles.
//   Sits between a requester (valid/ready in) and a consumer (valid/ready out) in the arithmetic path.
//   Trades latency for area: one 4-bit slice serves any multiple-of-4 width.
// PARAMETERS
//   WIDTH   16   operand/result width in bits; must be a multiple of 4 and >= 4 (N = WIDTH/4 nibbles)
// PORTS
//   clk        in   1      single clock, all state updates on rising edge
//   reset      in   1      asynchronous, active-high; clears all state immediately
//   in_valid   in   1      request present on a, b, carry_in, sub
//   in_ready   out  1      block can accept a request (high only in IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   carry_in   in   1      carry into bit 0 for add; ignored when sub=1
//   sub        in   1      0: A+B+carry_in ; 1: A-B (A + ~B + 1)
//   out_valid  out  1      result registered and stable (high only in DONE)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result
//   carry_out  out  1      carry out of bit WIDTH-1 (for sub: 1 = no borrow)
//   overflow   out  1      signed overflow of the operation
//   busy       out  1      high in RUN or DONE
// BEHAVIOUR
//   Reset (async, active-high): state=IDLE, nibble counter=0, carry reg=0, sum=0, carry_out=0,
//     overflow=0, out_valid=0, busy=0; in_ready=1 once reset deasserts. Reset mid-RUN/DONE discards
//     the operation; no partial result is ever flagged valid.
//   FSM states IDLE, RUN, DONE:
//     IDLE: in_ready=1. On edge with in_valid=1: latch a, b_eff = sub ? ~b : b, carry reg =
//       sub ? 1 : carry_in, counter=0, clear sum -> RUN. in_valid=0: stay.
//     RUN: each edge feeds slice with a[4i+3:4i], b_eff[4i+3:4i], carry reg (i = counter);
//       writes slice sum into sum[4i+3:4i], slice carry into carry reg, counter++.
//       On the edge where counter == N-1: also load carry_out and overflow -> DONE.
//     DONE: out_valid=1, outputs held stable. Edge with out_ready=1 -> IDLE (out_valid drops,
//       sum/carry_out/overflow keep last values). out_ready=0: hold indefinitely.
//   Latency: accept edge E; out_valid high after edge E+N (WIDTH=16: 4 edges). Min cycle between
//     accepts: N+2 (no accept in the cycle DONE is consumed, since in_ready=0 there).
//   Handshake: in_ready is a pure function of state (no combinational path from out_ready).
//     in_valid outside IDLE and out_ready outside DONE are ignored. Inputs need only be stable at
//     the accept edge; later changes to a/b/sub/carry_in do not affect the operation in flight.
//   Arithmetic: result is modulo 2^WIDTH; carry_out = final carry reg value.
//     overflow = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]).
//   busy = (state != IDLE). WIDTH=4 degenerates to one RUN cycle (N=1).
//   Illegal WIDTH (not a multiple of 4, or < 4): elaboration-time error.
// TESTING (WIDTH=16 unless noted)
//   1. Add 0x1234 + 0x0F0F, cin=0 -> after 4 RUN edges out_valid=1, sum=0x2143, cout=0, ovf=0.
//   2. Ripple across all nibbles: 0xFFFF + 0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0.
//   3. Sub 0x0005 - 0x0007 (cin=1 ignored) -> sum=0xFFFE, cout=0 (borrow), ovf=0;
//      sub 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
//   4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid/sum stable, in_ready=0,
//      new in_valid ignored; raise out_ready -> IDLE next edge, then next request accepted.
//   5. Assert reset during RUN (after 2 nibbles) -> all outputs 0 immediately, IDLE, no out_valid;
//      a following 0x0001 + 0x0001 returns 0x0002.
//   6. WIDTH=4: 0x9 + 0x8 -> out_valid after 1 edge, sum=0x1, cout=1, ovf=1; random
//      back-to-back sweep vs. reference model, WIDTH=4/8/16/32.

Source files
------------

// File: rtl/multicycle_adder_ctrl.sv
// Nibble-serial adder/subtractor: one shared 4-bit adder slice processes WIDTH/4 nibbles,
// LSB first, with the inter-nibble carry held in a register and valid/ready on both sides.

module full_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

module multicycle_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("multicycle_adder_ctrl: WIDTH=%0d must be a multiple of 4 and >= 4", WIDTH);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;       // already inverted for subtraction
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [3:0]       slice_sum;
  logic             slice_cout;

  assign last     = (cnt == CW'(N - 1));
  assign in_ready = (state == IDLE);

  full_adder_4bit u_slice (
    .a    (a_q[4*cnt +: 4]),
    .b    (b_q[4*cnt +: 4]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // NOTE: all state below is written with non-blocking assignments so every register
  // samples pre-edge values; the operand registers are reset too, keeping the slice inputs
  // defined while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : carry_in;
            cnt     <= '0;
            sum     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end

        RUN: begin
          sum[4*cnt +: 4] <= slice_sum;
          carry_q         <= slice_cout;
          cnt             <= cnt + 1'b1;
          if (last) begin
            // The top nibble is being written this edge, so its sign comes from the slice.
            carry_out <= slice_cout;
            overflow  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[3] != a_q[WIDTH-1]);
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_adder_ctrl.sv
// Bench for multicycle_adder_ctrl: four instances (WIDTH 4/8/16/32) driven by directed
// vectors, hand-written handshake/reset sequences and a random sweep against an arithmetic model.

module tb_multicycle_adder_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid  [4];
  logic        out_ready [4];
  logic        carry_in  [4];
  logic        sub       [4];
  logic [31:0] a_d       [4];
  logic [31:0] b_d       [4];
  logic        in_ready_w  [4];
  logic        out_valid_w [4];
  logic        carry_out_w [4];
  logic        overflow_w  [4];
  logic        busy_w      [4];
  logic [31:0] sum_w       [4];

  int n_cmp = 0;
  int n_bad = 0;

  // Instance k has WIDTH = 4 << k, i.e. N = 1 << k nibbles.
  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int W = 4 << k;
    logic [W-1:0] s;

    multicycle_adder_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready_w[k]),
      .a         (a_d[k][W-1:0]),
      .b         (b_d[k][W-1:0]),
      .carry_in  (carry_in[k]),
      .sub       (sub[k]),
      .out_valid (out_valid_w[k]),
      .out_ready (out_ready[k]),
      .sum       (s),
      .carry_out (carry_out_w[k]),
      .overflow  (overflow_w[k]),
      .busy      (busy_w[k])
    );

    assign sum_w[k] = 32'(s);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Arithmetic reference: plain modular/signed integer math on the operation's meaning.
  task automatic ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic s,
                           output logic [31:0] rs, output logic rc, output logic ro);
    longint unsigned m  = (64'd1 << w) - 1;
    longint unsigned ua = 64'(a) & m;
    longint unsigned ub = 64'(b) & m;
    longint          half = longint'(64'd1 << (w - 1));
    longint          sa = (ua >= 64'(half)) ? longint'(ua) - 2 * half : longint'(ua);
    longint          sb = (ub >= 64'(half)) ? longint'(ub) - 2 * half : longint'(ub);
    longint          r;
    longint unsigned full;
    if (s) begin
      full = (ua - ub) & m;
      rc   = (ua >= ub);
      r    = sa - sb;
    end else begin
      full = ua + ub + 64'(cin);
      rc   = full[w];
      r    = sa + sb + longint'(cin);
    end
    rs = 32'(full & m);
    ro = (r > half - 1) || (r < -half);
  endtask

  // Issue one operation on instance k, wait for the result, hold it `hold` cycles, consume it.
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic s, input int hold,
                        output logic [31:0] rs, output logic rc, output logic ro);
    int    j;
    string tag = $sformatf("w%0d", 4 << k);
    j = 0;
    while (!in_ready_w[k] && j < 100) begin
      @(negedge clk);
      j++;
    end
    check({tag, "_in_ready_wait"}, 64'(in_ready_w[k]), 64'd1);
    a_d[k] = a; b_d[k] = b; carry_in[k] = cin; sub[k] = s; in_valid[k] = 1'b1;
    @(negedge clk);
    // Scramble inputs after acceptance; the operation in flight must not notice.
    in_valid[k] = 1'b0; a_d[k] = $urandom; b_d[k] = $urandom; carry_in[k] = ~cin; sub[k] = ~s;
    check({tag, "_run_flags{busy,in_ready,out_valid}"},
          64'({busy_w[k], in_ready_w[k], out_valid_w[k]}), 64'(3'b100));
    j = 0;
    while (!out_valid_w[k] && j < 64) begin
      @(negedge clk);
      j++;
    end
    check({tag, "_latency"}, 64'(j), 64'(1 << k));
    repeat (hold) @(negedge clk);
    rs = sum_w[k]; rc = carry_out_w[k]; ro = overflow_w[k];
    check({tag, "_out_valid_held"}, 64'(out_valid_w[k]), 64'd1);
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    check({tag, "_after_consume{out_valid,in_ready,busy,sum}"},
          {29'd0, out_valid_w[k], in_ready_w[k], busy_w[k], sum_w[k]},
          {29'd0, 1'b0, 1'b1, 1'b0, rs});
  endtask

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] rs, es;
    logic        rc, ro, ec, eo;
    logic        seen_valid;

    vecs[0] = '{2, 32'h1234,     32'h0F0F,     1'b0, 1'b0, 32'h2143,     1'b0, 1'b0};
    vecs[1] = '{2, 32'hFFFF,     32'h0000,     1'b1, 1'b0, 32'h0000,     1'b1, 1'b0};
    vecs[2] = '{2, 32'h0005,     32'h0007,     1'b1, 1'b1, 32'hFFFE,     1'b0, 1'b0};
    vecs[3] = '{2, 32'h8000,     32'h0001,     1'b0, 1'b1, 32'h7FFF,     1'b1, 1'b1};
    vecs[4] = '{0, 32'h9,        32'h8,        1'b0, 1'b0, 32'h1,        1'b1, 1'b1};
    vecs[5] = '{3, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[6] = '{1, 32'h00,       32'h80,       1'b0, 1'b1, 32'h80,       1'b0, 1'b1};
    vecs[7] = '{3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};

    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; carry_in[k] = 1'b0; sub[k] = 1'b0;
      a_d[k] = '0; b_d[k] = '0;
    end
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("w%0d_reset_outputs", 4 << k),
            {28'd0, out_valid_w[k], busy_w[k], carry_out_w[k], overflow_w[k], sum_w[k]}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("w%0d_in_ready_after_reset", 4 << k), 64'(in_ready_w[k]), 64'd1);

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 0, rs, rc, ro);
      check($sformatf("vec%0d_result{sum,cout,ovf}", i), {30'd0, rs, rc, ro},
            {30'd0, vecs[i].s, vecs[i].co, vecs[i].ov});
    end

    // Backpressure: result held 10 cycles while a new request is waiting.
    a_d[2] = 32'hAAAA; b_d[2] = 32'h5555; carry_in[2] = 1'b0; sub[2] = 1'b0; in_valid[2] = 1'b1;
    @(negedge clk);
    in_valid[2] = 1'b0;
    for (int j = 0; j < 64 && !out_valid_w[2]; j++) @(negedge clk);
    a_d[2] = 32'h1111; b_d[2] = 32'h2222; in_valid[2] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d{out_valid,in_ready,sum}", j),
            {30'd0, out_valid_w[2], in_ready_w[2], sum_w[2]}, {30'd0, 1'b1, 1'b0, 32'hFFFF});
    end
    out_ready[2] = 1'b1;
    @(negedge clk);
    out_ready[2] = 1'b0;
    check("bp_consume{out_valid,in_ready,busy,sum}",
          {29'd0, out_valid_w[2], in_ready_w[2], busy_w[2], sum_w[2]},
          {29'd0, 1'b0, 1'b1, 1'b0, 32'hFFFF});
    @(negedge clk);
    in_valid[2] = 1'b0;
    check("bp_next_accept_busy", 64'(busy_w[2]), 64'd1);
    for (int j = 0; j < 64 && !out_valid_w[2]; j++) @(negedge clk);
    check("bp_next_result", 64'(sum_w[2]), 64'h3333);
    out_ready[2] = 1'b1;
    @(negedge clk);
    out_ready[2] = 1'b0;

    // Reset in the middle of RUN after two nibbles.
    a_d[2] = 32'hFFFF; b_d[2] = 32'hFFFF; carry_in[2] = 1'b1; sub[2] = 1'b0; in_valid[2] = 1'b1;
    @(negedge clk);
    in_valid[2] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrun_reset{out_valid,busy,cout,ovf,sum}",
          {28'd0, out_valid_w[2], busy_w[2], carry_out_w[2], overflow_w[2], sum_w[2]}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen_valid |= out_valid_w[2];
    end
    check("midrun_reset_no_valid", 64'(seen_valid), 64'd0);
    check("midrun_reset_idle_in_ready", 64'(in_ready_w[2]), 64'd1);
    run_op(2, 32'h0001, 32'h0001, 1'b0, 1'b0, 0, rs, rc, ro);
    check("after_reset_1p1{sum,cout,ovf}", {30'd0, rs, rc, ro}, {30'd0, 32'h0002, 1'b0, 1'b0});

    // Random sweep on every width against the arithmetic model.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 30; i++) begin
        logic [31:0] ra, rb;
        logic        rcin, rsub;
        ra = $urandom; rb = $urandom;
        if ($urandom_range(0, 5) == 0) ra = '1;
        if ($urandom_range(0, 5) == 0) rb = (i % 2 == 0) ? 32'h0 : 32'h80000000 >> (28 - 4 * (1 << k) + 4);
        rcin = 1'($urandom_range(0, 1));
        rsub = 1'($urandom_range(0, 1));
        run_op(k, ra, rb, rcin, rsub, $urandom_range(0, 3), rs, rc, ro);
        ref_model(4 << k, ra, rb, rcin, rsub, es, ec, eo);
        check($sformatf("rand_w%0d_%0d{sum,cout,ovf}", 4 << k, i),
              {30'd0, rs, rc, ro}, {30'd0, es, ec, eo});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
